// File: rtl/id_stage_pipe.sv
// id_stage_pipe: register file, load-use interlock with multi-cycle load shadow, WB bypass and ID/EX register.
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int CTRLW     = 12,
    parameter int LOAD_LAT  = 1,
    parameter int BYPASS_WB = 1,
    parameter int CNTW      = 16,
    localparam int AW       = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic [CTRLW-1:0] id_ctrl,
    input  logic             ex_ready,
    input  logic             ex_flush,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             id_stall,
    output logic             idex_valid,
    output logic             idex_regwrite,
    output logic             idex_memread,
    output logic [XLEN-1:0]  idex_pc,
    output logic [XLEN-1:0]  idex_imm,
    output logic [XLEN-1:0]  idex_rs1data,
    output logic [XLEN-1:0]  idex_rs2data,
    output logic [AW-1:0]    idex_rs1,
    output logic [AW-1:0]    idex_rs2,
    output logic [AW-1:0]    idex_rd,
    output logic [CTRLW-1:0] idex_ctrl,
    output logic [CNTW-1:0]  stall_cnt
);
    localparam int SH = LOAD_LAT > 1 ? LOAD_LAT - 1 : 1;

    logic [XLEN-1:0]  rf_q [NREG];
    logic [XLEN-1:0]  rf_d [NREG];
    logic [SH-1:0]    sh_v_q, sh_v_d;
    logic [AW-1:0]    sh_rd_q [SH];
    logic [AW-1:0]    sh_rd_d [SH];
    logic             idex_valid_q, idex_valid_d, idex_regwrite_q, idex_regwrite_d;
    logic             idex_memread_q, idex_memread_d;
    logic [XLEN-1:0]  idex_pc_q, idex_pc_d, idex_imm_q, idex_imm_d;
    logic [XLEN-1:0]  idex_rs1data_q, idex_rs1data_d, idex_rs2data_q, idex_rs2data_d;
    logic [AW-1:0]    idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d, idex_rd_q, idex_rd_d;
    logic [CTRLW-1:0] idex_ctrl_q, idex_ctrl_d;
    logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0]  rs1_data, rs2_data;
    logic             hit1, hit2, hazard, bubble;

    assign rs1_data = (id_rs1 == '0) ? '0 :
                      (BYPASS_WB != 0 && wb_we && wb_rd == id_rs1) ? wb_data : rf_q[id_rs1];
    assign rs2_data = (id_rs2 == '0) ? '0 :
                      (BYPASS_WB != 0 && wb_we && wb_rd == id_rs2) ? wb_data : rf_q[id_rs2];

    // a load is pending while it sits in ID/EX or in any of the LOAD_LAT-1 shadow slots behind it
    always_comb begin
        hit1 = idex_valid_q && idex_memread_q && idex_rd_q == id_rs1;
        hit2 = idex_valid_q && idex_memread_q && idex_rd_q == id_rs2;
        for (int k = 0; k < LOAD_LAT - 1; k++) begin
            hit1 = hit1 || (sh_v_q[k] && sh_rd_q[k] == id_rs1);
            hit2 = hit2 || (sh_v_q[k] && sh_rd_q[k] == id_rs2);
        end
    end

    assign hazard   = id_valid && ((id_rs1_used && id_rs1 != '0 && hit1) ||
                                   (id_rs2_used && id_rs2 != '0 && hit2));
    assign bubble   = ex_flush || hazard;
    assign id_stall = !rstb && (!ex_ready || (!ex_flush && hazard));

    always_comb begin
        rf_d = rf_q;
        if (wb_we && wb_rd != '0) rf_d[wb_rd] = wb_data;
        sh_v_d          = sh_v_q;
        sh_rd_d         = sh_rd_q;
        idex_valid_d    = idex_valid_q;
        idex_regwrite_d = idex_regwrite_q;
        idex_memread_d  = idex_memread_q;
        idex_ctrl_d     = idex_ctrl_q;
        idex_pc_d       = idex_pc_q;
        idex_imm_d      = idex_imm_q;
        idex_rs1data_d  = idex_rs1data_q;
        idex_rs2data_d  = idex_rs2data_q;
        idex_rs1_d      = idex_rs1_q;
        idex_rs2_d      = idex_rs2_q;
        idex_rd_d       = idex_rd_q;
        stall_cnt_d     = stall_cnt_q;
        if (ex_ready) begin
            if (LOAD_LAT > 1) begin
                sh_v_d[0]  = idex_valid_q && idex_memread_q && idex_rd_q != '0;
                sh_rd_d[0] = idex_rd_q;
                for (int k = 1; k < SH; k++) begin
                    sh_v_d[k]  = sh_v_q[k-1];
                    sh_rd_d[k] = sh_rd_q[k-1];
                end
            end
            idex_valid_d    = bubble ? 1'b0 : id_valid;
            idex_regwrite_d = bubble ? 1'b0 : id_regwrite;
            idex_memread_d  = bubble ? 1'b0 : id_memread;
            idex_ctrl_d     = bubble ? '0 : id_ctrl;
            idex_pc_d       = id_pc;
            idex_imm_d      = id_imm;
            idex_rs1data_d  = rs1_data;
            idex_rs2data_d  = rs2_data;
            idex_rs1_d      = id_rs1;
            idex_rs2_d      = id_rs2;
            idex_rd_d       = id_rd;
            stall_cnt_d     = (!ex_flush && hazard && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            rf_q            <= '{default: '0};
            sh_v_q          <= '0;
            sh_rd_q         <= '{default: '0};
            idex_valid_q    <= 1'b0;
            idex_regwrite_q <= 1'b0;
            idex_memread_q  <= 1'b0;
            idex_ctrl_q     <= '0;
            idex_pc_q       <= '0;
            idex_imm_q      <= '0;
            idex_rs1data_q  <= '0;
            idex_rs2data_q  <= '0;
            idex_rs1_q      <= '0;
            idex_rs2_q      <= '0;
            idex_rd_q       <= '0;
            stall_cnt_q     <= '0;
        end else begin
            rf_q            <= rf_d;
            sh_v_q          <= sh_v_d;
            sh_rd_q         <= sh_rd_d;
            idex_valid_q    <= idex_valid_d;
            idex_regwrite_q <= idex_regwrite_d;
            idex_memread_q  <= idex_memread_d;
            idex_ctrl_q     <= idex_ctrl_d;
            idex_pc_q       <= idex_pc_d;
            idex_imm_q      <= idex_imm_d;
            idex_rs1data_q  <= idex_rs1data_d;
            idex_rs2data_q  <= idex_rs2data_d;
            idex_rs1_q      <= idex_rs1_d;
            idex_rs2_q      <= idex_rs2_d;
            idex_rd_q       <= idex_rd_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign idex_valid    = idex_valid_q;
    assign idex_regwrite = idex_regwrite_q;
    assign idex_memread  = idex_memread_q;
    assign idex_ctrl     = idex_ctrl_q;
    assign idex_pc       = idex_pc_q;
    assign idex_imm      = idex_imm_q;
    assign idex_rs1data  = idex_rs1data_q;
    assign idex_rs2data  = idex_rs2data_q;
    assign idex_rs1      = idex_rs1_q;
    assign idex_rs2      = idex_rs2_q;
    assign idex_rd       = idex_rd_q;
    assign stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: four instances (LOAD_LAT 1/2/3 with bypass, LOAD_LAT 2 without) driven in lockstep.
module tb_id_stage_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstb, id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread;
    logic        ex_ready, ex_flush, wb_we;
    logic [31:0] id_pc, id_imm, wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [11:0] id_ctrl;

    logic        stall_o [4];
    logic        v_o [4];
    logic        rw_o [4];
    logic        mr_o [4];
    logic [31:0] pc_o [4];
    logic [31:0] imm_o [4];
    logic [31:0] d1_o [4];
    logic [31:0] d2_o [4];
    logic [4:0]  r1_o [4];
    logic [4:0]  r2_o [4];
    logic [4:0]  rd_o [4];
    logic [11:0] ctrl_o [4];
    logic [3:0]  cnt_o [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        id_stage_pipe #(.LOAD_LAT(g == 3 ? 2 : g + 1), .BYPASS_WB(g == 3 ? 0 : 1), .CNTW(4)) u_dut (
            .clk(clk), .rstb(rstb), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
            .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_used(id_rs1_used),
            .id_rs2_used(id_rs2_used), .id_regwrite(id_regwrite), .id_memread(id_memread),
            .id_ctrl(id_ctrl), .ex_ready(ex_ready), .ex_flush(ex_flush), .wb_we(wb_we),
            .wb_rd(wb_rd), .wb_data(wb_data), .id_stall(stall_o[g]), .idex_valid(v_o[g]),
            .idex_regwrite(rw_o[g]), .idex_memread(mr_o[g]), .idex_pc(pc_o[g]),
            .idex_imm(imm_o[g]), .idex_rs1data(d1_o[g]), .idex_rs2data(d2_o[g]),
            .idex_rs1(r1_o[g]), .idex_rs2(r2_o[g]), .idex_rd(rd_o[g]), .idex_ctrl(ctrl_o[g]),
            .stall_cnt(cnt_o[g])
        );
    end

    // reference: per-register countdown of EX advances until a load result is forwardable
    logic [31:0] m_rf [4][32];
    int          m_busy [4][32];
    logic        m_v [4];
    logic        m_rw [4];
    logic        m_mr [4];
    logic [31:0] m_pc [4];
    logic [31:0] m_imm [4];
    logic [31:0] m_d1 [4];
    logic [31:0] m_d2 [4];
    logic [4:0]  m_r1 [4];
    logic [4:0]  m_r2 [4];
    logic [4:0]  m_rd [4];
    logic [11:0] m_ctrl [4];
    int          m_cnt [4];
    int          n_cmp = 0, n_err = 0;

    function automatic int lat(input int i);
        return i == 3 ? 2 : i + 1;
    endfunction

    function automatic logic m_haz(input int i);
        return id_valid && ((id_rs1_used && id_rs1 != 0 && m_busy[i][id_rs1] > 0) ||
                            (id_rs2_used && id_rs2 != 0 && m_busy[i][id_rs2] > 0));
    endfunction

    function automatic logic m_stall(input int i);
        return !rstb && (!ex_ready || (!ex_flush && m_haz(i)));
    endfunction

    function automatic logic [31:0] m_read(input int i, input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (i != 3 && wb_we && wb_rd == r) return wb_data;
        return m_rf[i][r];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 32; r++) begin
                m_rf[i][r] = 0;
                m_busy[i][r] = 0;
            end
            m_v[i] = 0; m_rw[i] = 0; m_mr[i] = 0; m_ctrl[i] = 0; m_cnt[i] = 0;
            m_pc[i] = 0; m_imm[i] = 0; m_d1[i] = 0; m_d2[i] = 0;
            m_r1[i] = 0; m_r2[i] = 0; m_rd[i] = 0;
        end
    endtask

    task automatic m_update();
        logic haz, bub;
        if (rstb) begin
            m_clear();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (ex_ready) begin
                haz = m_haz(i);
                bub = ex_flush || haz;
                m_d1[i] = m_read(i, id_rs1);
                m_d2[i] = m_read(i, id_rs2);
                m_pc[i] = id_pc; m_imm[i] = id_imm;
                m_r1[i] = id_rs1; m_r2[i] = id_rs2; m_rd[i] = id_rd;
                m_v[i]  = !bub && id_valid;
                m_rw[i] = !bub && id_regwrite;
                m_mr[i] = !bub && id_memread;
                m_ctrl[i] = bub ? 12'h0 : id_ctrl;
                for (int r = 0; r < 32; r++) if (m_busy[i][r] > 0) m_busy[i][r]--;
                if (m_v[i] && m_mr[i] && id_rd != 0) m_busy[i][id_rd] = lat(i);
                if (!ex_flush && haz && m_cnt[i] < 15) m_cnt[i]++;
            end
            if (wb_we && wb_rd != 0) m_rf[i][wb_rd] = wb_data;
        end
    endtask

    task automatic chk(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d: got %h expected %h at %0t", nm, ln, act, exp, $time);
        end
    endtask

    task automatic cyc_check();
        @(negedge clk);
        if (rstb) m_clear();
        for (int i = 0; i < 4; i++) begin
            chk("id_stall", i, stall_o[i], m_stall(i));
            chk("idex_valid", i, v_o[i], m_v[i]);
            chk("idex_regwrite", i, rw_o[i], m_rw[i]);
            chk("idex_memread", i, mr_o[i], m_mr[i]);
            chk("idex_ctrl", i, ctrl_o[i], m_ctrl[i]);
            chk("stall_cnt", i, cnt_o[i], m_cnt[i]);
            chk("idex_pc", i, pc_o[i], m_pc[i]);
            chk("idex_imm", i, imm_o[i], m_imm[i]);
            chk("idex_rs1data", i, d1_o[i], m_d1[i]);
            chk("idex_rs2data", i, d2_o[i], m_d2[i]);
            chk("idex_rs1", i, r1_o[i], m_r1[i]);
            chk("idex_rs2", i, r2_o[i], m_r2[i]);
            chk("idex_rd", i, rd_o[i], m_rd[i]);
        end
    endtask

    task automatic cyc_adv();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic mr, input logic rw);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_used = u1; id_rs2_used = u2; id_memread = mr; id_regwrite = rw;
        id_ctrl = v ? 12'hA5C : 12'h0;
        id_pc = id_pc + 4; id_imm = {27'h0, rd};
    endtask

    typedef struct {
        logic       v, u1, u2, mr, rw;
        logic [4:0] r1, r2, rd;
        logic       s1, s3, v1, v3;
        int         c1, c3;
    } vec_t;

    vec_t tbl [15];
    int   exp_st [5];

    initial begin
        // lw x5 / nop / add x6,x5,x1 / idle (expected id_stall, idex_valid, stall_cnt for LOAD_LAT 1 and 3)
        tbl[0]  = '{1,1,0,1,1, 1,0,5, 0,0, 0,0, 0,0};
        tbl[1]  = '{1,1,0,0,0, 0,0,0, 0,0, 1,1, 0,0};
        tbl[2]  = '{1,1,1,0,1, 5,1,6, 0,1, 1,1, 0,0};
        tbl[3]  = '{1,1,1,0,1, 5,1,6, 0,1, 1,0, 0,1};
        tbl[4]  = '{1,1,1,0,1, 5,1,6, 0,0, 1,0, 0,2};
        tbl[5]  = '{0,0,0,0,0, 0,0,0, 0,0, 1,1, 0,2};
        tbl[6]  = '{1,1,0,1,1, 1,0,5, 0,0, 0,0, 0,2};
        tbl[7]  = '{1,1,1,0,1, 5,1,6, 1,1, 1,1, 0,2};
        tbl[8]  = '{1,1,1,0,1, 5,1,6, 0,1, 0,0, 1,3};
        tbl[9]  = '{0,0,0,0,0, 0,0,0, 0,0, 1,0, 1,4};
        tbl[10] = '{0,0,0,0,0, 0,0,0, 0,0, 0,0, 1,4};
        tbl[11] = '{1,1,0,1,1, 1,0,5, 0,0, 0,0, 1,4};
        tbl[12] = '{1,1,0,0,0, 0,0,0, 0,0, 1,1, 1,4};
        tbl[13] = '{1,1,1,0,1, 7,1,6, 0,0, 1,1, 1,4};
        tbl[14] = '{0,0,0,0,0, 0,0,0, 0,0, 1,1, 1,4};

        rstb = 1; id_pc = 0; id_imm = 0; id_ctrl = 0; ex_ready = 1; ex_flush = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        m_clear();
        cyc_check();
        @(posedge clk);
        #1 rstb = 0;

        foreach (tbl[n]) begin
            instr(tbl[n].v, tbl[n].r1, tbl[n].r2, tbl[n].rd, tbl[n].u1, tbl[n].u2, tbl[n].mr, tbl[n].rw);
            cyc_check();
            chk($sformatf("tbl%0d stall", n), 0, stall_o[0], tbl[n].s1);
            chk($sformatf("tbl%0d stall", n), 2, stall_o[2], tbl[n].s3);
            chk($sformatf("tbl%0d valid", n), 0, v_o[0], tbl[n].v1);
            chk($sformatf("tbl%0d valid", n), 2, v_o[2], tbl[n].v3);
            chk($sformatf("tbl%0d cnt", n), 0, cnt_o[0], tbl[n].c1);
            chk($sformatf("tbl%0d cnt", n), 2, cnt_o[2], tbl[n].c3);
            cyc_adv();
        end

        // writeback bypass, x0 handling, and the non-bypass lane seeing the value one cycle later
        instr(1, 7, 0, 8, 1, 0, 0, 1);
        wb_we = 1; wb_rd = 7; wb_data = 32'hDEADBEEF;
        cyc_check(); cyc_adv();
        instr(1, 0, 0, 8, 1, 0, 0, 1);
        wb_rd = 0; wb_data = 32'h12345678;
        cyc_check();
        for (int i = 0; i < 3; i++) chk("bypass rs1data", i, d1_o[i], 32'hDEADBEEF);
        chk("nobypass rs1data", 3, d1_o[3], 32'h0);
        cyc_adv();
        instr(1, 7, 0, 8, 1, 0, 0, 1);
        wb_we = 0;
        cyc_check();
        for (int i = 0; i < 4; i++) chk("x0 rs1data", i, d1_o[i], 32'h0);
        cyc_adv();
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        cyc_check();
        chk("late rs1data", 3, d1_o[3], 32'hDEADBEEF);
        cyc_adv();

        // EX backpressure holds ID/EX and ignores flush
        instr(1, 1, 0, 9, 1, 0, 0, 1);
        id_pc = 32'h100;
        cyc_check(); cyc_adv();
        for (int k = 0; k < 3; k++) begin
            instr(1, 2, 0, 10, 1, 0, 0, 1);
            ex_ready = 0; ex_flush = (k == 1);
            cyc_check();
            chk("hold pc", 0, pc_o[0], 32'h100);
            chk("hold valid", 0, v_o[0], 1'b1);
            chk("hold stall", 0, stall_o[0], 1'b1);
            cyc_adv();
        end
        ex_ready = 1; ex_flush = 0;

        // load-use hazard coinciding with flush: bubble, no stall, counter untouched
        instr(1, 1, 0, 5, 1, 0, 1, 1);
        cyc_check(); cyc_adv();
        instr(1, 5, 1, 6, 1, 1, 0, 1);
        ex_flush = 1;
        cyc_check();
        chk("flush+haz stall", 0, stall_o[0], 1'b0);
        cyc_adv();
        ex_flush = 0;
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        cyc_check();
        chk("flush bubble", 0, v_o[0], 1'b0);
        chk("flush cnt", 0, cnt_o[0], 4'd1);
        cyc_adv();

        // asynchronous reset in the middle of a LOAD_LAT=2 stall
        instr(1, 1, 0, 5, 1, 0, 1, 1);
        cyc_check(); cyc_adv();
        instr(1, 5, 1, 6, 1, 1, 0, 1);
        cyc_check();
        chk("pre-reset stall", 1, stall_o[1], 1'b1);
        #2 rstb = 1;
        #1;
        m_clear();
        chk("reset stall", 1, stall_o[1], 1'b0);
        chk("reset valid", 1, v_o[1], 1'b0);
        chk("reset pc", 1, pc_o[1], 32'h0);
        chk("reset cnt", 1, cnt_o[1], 4'd0);
        @(posedge clk);
        #1 rstb = 0;
        exp_st = '{0, 1, 1, 0, 0};
        for (int k = 0; k < 5; k++) begin
            if (k == 0) instr(1, 1, 0, 5, 1, 0, 1, 1);
            else if (k < 4) instr(1, 5, 1, 6, 1, 1, 0, 1);
            else instr(0, 0, 0, 0, 0, 0, 0, 0);
            cyc_check();
            chk($sformatf("fresh stall%0d", k), 1, stall_o[1], exp_st[k]);
            cyc_adv();
        end
        cyc_check();
        chk("fresh cnt", 1, cnt_o[1], 4'd2);
        cyc_adv();

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            id_valid    = $urandom_range(0, 9) < 8;
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom);
            id_rs2_used = 1'($urandom);
            id_memread  = $urandom_range(0, 2) == 0;
            id_regwrite = 1'($urandom);
            id_ctrl     = 12'($urandom);
            id_pc       = $urandom;
            id_imm      = $urandom;
            ex_ready    = $urandom_range(0, 4) != 0;
            ex_flush    = $urandom_range(0, 9) == 0;
            wb_we       = 1'($urandom);
            wb_rd       = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            rstb        = $urandom_range(0, 199) == 0;
            cyc_check();
            cyc_adv();
        end
        rstb = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
